// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire wrapper around a combinational N-bit ALU: decodes the
// ALU control code, adds SLT and signed overflow, and registers the result.

module n_bit_ALU #(
  parameter int N = 64
) (
  input  logic         ainvert,
  input  logic         binvert,
  input  logic         cin,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result
);
  logic [N-1:0] a_eff;
  logic [N-1:0] b_eff;
  logic [N-1:0] and_bits;
  logic [N-1:0] or_bits;
  logic [N-1:0] sum_bits;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign a_eff[gi]    = a[gi] ^ ainvert;
      assign b_eff[gi]    = b[gi] ^ binvert;
      assign and_bits[gi] = a_eff[gi] & b_eff[gi];
      assign or_bits[gi]  = a_eff[gi] | b_eff[gi];
    end
  endgenerate

  assign sum_bits = a_eff + b_eff + {{(N-1){1'b0}}, cin};

  always_comb begin
    result = '0;
    case (op)
      2'b00:   result = and_bits;
      2'b01:   result = or_bits;
      2'b10:   result = sum_bits;
      default: result = '0;
    endcase
  end
endmodule

module alu_issue_stage #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_ctl,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_zero,
  output logic         out_ovf,
  output logic         out_illegal
);
  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SLT  = 4'b0111;
  localparam logic [3:0] CTL_NOR  = 4'b1100;
  localparam logic [3:0] CTL_NAND = 4'b1101;

  logic         dec_ainv, dec_binv, dec_cin, dec_illegal;
  logic [1:0]   dec_op;

  logic         s1_valid_reg;
  logic [3:0]   s1_ctl_reg;
  logic [N-1:0] s1_a_reg, s1_b_reg;
  logic         s1_ainv_reg, s1_binv_reg, s1_cin_reg, s1_illegal_reg;
  logic [1:0]   s1_op_reg;

  logic         s2_valid_reg;
  logic [N-1:0] s2_result_reg;
  logic         s2_zero_reg, s2_ovf_reg, s2_illegal_reg;

  logic [N-1:0] alu_result;
  logic [N-1:0] s2_result_next;
  logic         s2_zero_next, s2_ovf_next;
  logic         ovf_add, ovf_sub;
  logic         s1_adv, s2_adv;

  always_comb begin
    dec_ainv    = 1'b0;
    dec_binv    = 1'b0;
    dec_cin     = 1'b0;
    dec_op      = 2'b00;
    dec_illegal = 1'b0;
    case (in_ctl)
      CTL_AND:  dec_op = 2'b00;
      CTL_OR:   dec_op = 2'b01;
      CTL_ADD:  dec_op = 2'b10;
      CTL_SUB, CTL_SLT: begin
        dec_binv = 1'b1;
        dec_cin  = 1'b1;
        dec_op   = 2'b10;
      end
      CTL_NOR: begin
        dec_ainv = 1'b1;
        dec_binv = 1'b1;
        dec_op   = 2'b00;
      end
      CTL_NAND: begin
        dec_ainv = 1'b1;
        dec_binv = 1'b1;
        dec_op   = 2'b01;
      end
      default:  dec_illegal = 1'b1;
    endcase
  end

  // in_ready looks through both stages so a full pipe can refill on the retire edge.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s1_ctl_reg     <= '0;
      s1_a_reg       <= '0;
      s1_b_reg       <= '0;
      s1_ainv_reg    <= 1'b0;
      s1_binv_reg    <= 1'b0;
      s1_cin_reg     <= 1'b0;
      s1_op_reg      <= 2'b00;
      s1_illegal_reg <= 1'b0;
    end else begin
      if (s1_adv) s1_valid_reg <= in_valid;
      if (in_valid && s1_adv) begin
        s1_ctl_reg     <= in_ctl;
        s1_a_reg       <= in_a;
        s1_b_reg       <= in_b;
        s1_ainv_reg    <= dec_ainv;
        s1_binv_reg    <= dec_binv;
        s1_cin_reg     <= dec_cin;
        s1_op_reg      <= dec_op;
        s1_illegal_reg <= dec_illegal;
      end
    end
  end

  n_bit_ALU #(.N(N)) u_alu (
    .ainvert (s1_ainv_reg),
    .binvert (s1_binv_reg),
    .cin     (s1_cin_reg),
    .op      (s1_op_reg),
    .a       (s1_a_reg),
    .b       (s1_b_reg),
    .result  (alu_result)
  );

  assign ovf_add = (s1_a_reg[N-1] == s1_b_reg[N-1]) && (alu_result[N-1] != s1_a_reg[N-1]);
  assign ovf_sub = (s1_a_reg[N-1] != s1_b_reg[N-1]) && (alu_result[N-1] != s1_a_reg[N-1]);

  always_comb begin
    s2_result_next = alu_result;
    s2_ovf_next    = 1'b0;
    if (s1_illegal_reg) begin
      s2_result_next = '0;
    end else if (s1_ctl_reg == CTL_SLT) begin
      // Sign of the difference, corrected when the subtraction overflowed.
      s2_result_next = {{(N-1){1'b0}}, alu_result[N-1] ^ ovf_sub};
    end else if (s1_ctl_reg == CTL_ADD) begin
      s2_ovf_next = ovf_add;
    end else if (s1_ctl_reg == CTL_SUB) begin
      s2_ovf_next = ovf_sub;
    end
    s2_zero_next = (s2_result_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_reg   <= 1'b0;
      s2_result_reg  <= '0;
      s2_zero_reg    <= 1'b0;
      s2_ovf_reg     <= 1'b0;
      s2_illegal_reg <= 1'b0;
    end else begin
      if (s2_adv) s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg && s2_adv) begin
        s2_result_reg  <= s2_result_next;
        s2_zero_reg    <= s2_zero_next;
        s2_ovf_reg     <= s2_ovf_next;
        s2_illegal_reg <= s1_illegal_reg;
      end
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_result  = s2_result_reg;
  assign out_zero    = s2_zero_reg;
  assign out_ovf     = s2_ovf_reg;
  assign out_illegal = s2_illegal_reg;
endmodule
